snoop_ctrl_engine: RTL

SNOOP_CTRL_ENGINE -- requirements
Module: snoop_ctrl_engine

---
 rtl/snoop_ctrl_engine.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/snoop_ctrl_engine.sv
// Snoop control engine: queues incoming snoops, consults the snoop filter,
// fans requests out to the sharing cores, forwards dirty data and responds.
module snoop_ctrl_engine #(
    parameter int NUM_CORES   = 8,
    parameter int ADDR_W      = 48,
    parameter int ID_W        = 6,
    parameter int DATA_W      = 512,
    parameter int QDEPTH      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ac_valid,
    output logic                 ac_ready,
    input  logic [ADDR_W-1:0]    ac_addr,
    input  logic [3:0]           ac_snoop,
    input  logic [ID_W-1:0]      ac_id,
    output logic                 sf_lookup,
    output logic [ADDR_W-1:0]    sf_addr,
    input  logic                 sf_hit,
    input  logic [NUM_CORES-1:0] sf_share,
    output logic [NUM_CORES-1:0] core_req,
    input  logic [NUM_CORES-1:0] core_ack,
    input  logic [NUM_CORES-1:0] core_shared,
    input  logic [NUM_CORES-1:0] core_dirty,
    input  logic                 core_dvalid,
    input  logic                 core_dlast,
    input  logic [DATA_W-1:0]    core_data,
    output logic                 core_dready,
    output logic                 cr_valid,
    input  logic                 cr_ready,
    output logic [4:0]           cr_resp,
    output logic [ID_W-1:0]      cr_id,
    output logic                 cd_valid,
    input  logic                 cd_ready,
    output logic [DATA_W-1:0]    cd_data,
    output logic                 cd_last,
    output logic                 dvm_complete,
    output logic [31:0]          snoop_count,
    output logic [31:0]          dvm_count,
    output logic [31:0]          timeout_count,
    output logic [2:0]           fsm_state
);

    // state   | meaning
    // IDLE    | wait for a queued snoop, pop it into the working registers
    // LOOKUP  | one-cycle snoop filter query, latch the target core mask
    // REQUEST | drive core_req until every pending core has acked
    // DATA    | pass dirty data beats from the owner to the cd channel
    // RESP    | hold the response until cr_ready
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        REQUEST = 3'd2,
        DATA    = 3'd3,
        RESP    = 3'd4
    } state_e;

    localparam logic [3:0] SNP_RNS   = 4'd0;
    localparam logic [3:0] SNP_RU    = 4'd3;
    localparam logic [3:0] SNP_WI    = 4'd6;
    localparam logic [3:0] SNP_EVICT = 4'd7;
    localparam logic [3:0] SNP_DVM   = 4'd8;

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int ENT_W = ADDR_W + 4 + ID_W;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(QDEPTH);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    state_e                state_q, state_d;
    logic [ENT_W-1:0]      fifo_mem [QDEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic                  rdy_en_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [3:0]            snoop_q;
    logic [ID_W-1:0]       id_q;
    logic [NUM_CORES-1:0]  mask_q, mask_d;
    logic                  shared_q, shared_d;
    logic                  dirty_q, dirty_d;
    logic                  err_q, err_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  dvm_q;
    logic [31:0]           snoop_cnt_q, dvm_cnt_q, tmo_cnt_q;

    logic                  full, empty, push, pop, tmo;
    logic [ENT_W-1:0]      head;
    logic [ADDR_W-1:0]     head_addr;
    logic [3:0]            head_snp_raw, head_snp;
    logic [ID_W-1:0]       head_id;
    logic                  head_dvm;
    logic                  filt_bypass, no_share;
    logic [NUM_CORES-1:0]  lk_mask, acked, pend_left;

    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign ac_ready = rdy_en_q && !full;
    assign push     = ac_valid && ac_ready;
    assign pop      = (state_q == IDLE) && !empty;

    assign head         = fifo_mem[rd_ptr_q];
    assign head_addr    = head[ENT_W-1 -: ADDR_W];
    assign head_snp_raw = head[ID_W +: 4];
    assign head_id      = head[ID_W-1:0];
    // Reserved encodings above DVM behave as ReadNoSnoop.
    assign head_snp     = (head_snp_raw > SNP_DVM) ? SNP_RNS : head_snp_raw;
    assign head_dvm     = (head_snp == SNP_DVM);

    assign filt_bypass = (snoop_q == SNP_RNS) || (snoop_q == SNP_EVICT);
    assign no_share    = (snoop_q == SNP_RU) || (snoop_q == SNP_WI);
    assign lk_mask     = (sf_hit && !filt_bypass) ? sf_share : '0;
    assign acked       = core_ack & mask_q;
    assign pend_left   = mask_q & ~acked;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        shared_d    = shared_q;
        dirty_d     = dirty_q;
        err_d       = err_q;
        timer_d     = timer_q;
        tmo         = 1'b0;
        sf_lookup   = 1'b0;
        sf_addr     = '0;
        core_req    = '0;
        core_dready = 1'b0;
        cd_valid    = 1'b0;
        cd_data     = '0;
        cd_last     = 1'b0;
        cr_valid    = 1'b0;
        cr_resp     = '0;
        cr_id       = '0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    mask_d   = '0;
                    shared_d = 1'b0;
                    dirty_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = head_dvm ? RESP : LOOKUP;
                end
            end
            LOOKUP: begin
                sf_lookup = 1'b1;
                sf_addr   = addr_q;
                mask_d    = lk_mask;
                if (lk_mask == '0) begin
                    state_d = RESP;
                end else begin
                    state_d = REQUEST;
                    timer_d = TMR_LOAD;
                end
            end
            REQUEST: begin
                core_req = mask_q;
                mask_d   = pend_left;
                shared_d = shared_q | (|(core_shared & acked));
                dirty_d  = dirty_q | (|(core_dirty & acked));
                // A final ack arriving on the terminal cycle still completes normally.
                if (pend_left == '0) begin
                    if (dirty_d) begin
                        state_d = DATA;
                        timer_d = TMR_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end else if (timer_q == '0) begin
                    tmo     = 1'b1;
                    mask_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            DATA: begin
                core_dready = cd_ready;
                cd_valid    = core_dvalid;
                cd_data     = core_data;
                cd_last     = core_dlast;
                if (core_dvalid && cd_ready && core_dlast) begin
                    state_d = RESP;
                end else if (timer_q == '0) begin
                    tmo     = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            RESP: begin
                cr_valid = 1'b1;
                cr_id    = id_q;
                cr_resp  = {1'b0, shared_q & ~no_share, dirty_q & ~err_q, err_q, dirty_q & ~err_q};
                if (cr_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rdy_en_q    <= 1'b0;
            addr_q      <= '0;
            snoop_q     <= '0;
            id_q        <= '0;
            mask_q      <= '0;
            shared_q    <= 1'b0;
            dirty_q     <= 1'b0;
            err_q       <= 1'b0;
            timer_q     <= '0;
            dvm_q       <= 1'b0;
            snoop_cnt_q <= '0;
            dvm_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
            mask_q   <= mask_d;
            shared_q <= shared_d;
            dirty_q  <= dirty_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            dvm_q    <= pop && head_dvm;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                addr_q   <= head_addr;
                snoop_q  <= head_snp;
                id_q     <= head_id;
                if (head_dvm) begin
                    dvm_cnt_q <= dvm_cnt_q + 32'd1;
                end else begin
                    snoop_cnt_q <= snoop_cnt_q + 32'd1;
                end
            end
            if (tmo) begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {ac_addr, ac_snoop, ac_id};
        end
    end

    assign dvm_complete  = dvm_q;
    assign snoop_count   = snoop_cnt_q;
    assign dvm_count     = dvm_cnt_q;
    assign timeout_count = tmo_cnt_q;
    assign fsm_state     = state_q;

endmodule
